// File: rtl/imem_access_arbiter.sv
// Arbitrates one single-port, synchronous-read instruction memory between the
// fetch unit (read-only) and the loader/debug port (read/write).
module imem_access_arbiter #(
    parameter int DEPTH        = 1024,
    parameter int AW           = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    output logic          f_err,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    input  logic          l_lock,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    output logic          l_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_t;

    logic [3:0] starve_cnt;
    owner_t     rsp_owner;
    logic       rsp_err;
    logic       rsp_write;
    logic       f_fault;
    logic       l_fault;
    logic       starved;

    // Misaligned or beyond the array: granted, but never touches memory.
    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
    endfunction

    assign f_fault = addr_fault(f_addr);
    assign l_fault = addr_fault(l_addr);
    assign starved = (starve_cnt == 4'(STARVE_LIMIT));

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (rst) begin
            if (l_lock) begin
                l_gnt = l_req;
            end else if (starved && f_req) begin
                f_gnt = 1'b1;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end else begin
                f_gnt = f_req;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = f_addr[AW+1:2];
        mem_wdata = l_wdata;
        if (l_gnt) begin
            mem_addr = l_addr[AW+1:2];
            mem_en   = !l_fault;
            mem_we   = l_we && !l_fault;
        end else if (f_gnt) begin
            mem_en = !f_fault;
        end
    end

    // Fetch waits while the loader is served; after STARVE_LIMIT such cycles it
    // takes one slot. Loader-only mode keeps the count parked at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
            rsp_owner  <= OWN_NONE;
            rsp_err    <= 1'b0;
            rsp_write  <= 1'b0;
        end else begin
            if (l_lock || !f_req || f_gnt) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            if (l_gnt) begin
                rsp_owner <= OWN_LOADER;
                rsp_err   <= l_fault;
                rsp_write <= l_we;
            end else if (f_gnt) begin
                rsp_owner <= OWN_FETCH;
                rsp_err   <= f_fault;
                rsp_write <= 1'b0;
            end else begin
                rsp_owner <= OWN_NONE;
                rsp_err   <= 1'b0;
                rsp_write <= 1'b0;
            end
        end
    end

    // Faults and writes return zero data instead of whatever the array drives.
    assign f_rvalid = (rsp_owner == OWN_FETCH);
    assign f_err    = f_rvalid && rsp_err;
    assign f_rdata  = (f_rvalid && !rsp_err) ? mem_rdata : 32'h0;
    assign l_rvalid = (rsp_owner == OWN_LOADER);
    assign l_err    = l_rvalid && rsp_err;
    assign l_rdata  = (l_rvalid && !rsp_err && !rsp_write) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Self-checking bench for imem_access_arbiter: directed vector table, reset and
// starvation sequences, then random traffic against a transaction-level model.
module tb_imem_access_arbiter;

    localparam int DEPTH        = 1024;
    localparam int AW           = 10;
    localparam int STARVE_LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req;
    logic [31:0]   f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [31:0]   f_rdata;
    logic          f_err;
    logic          l_req;
    logic          l_we;
    logic [31:0]   l_addr;
    logic [31:0]   l_wdata;
    logic          l_lock;
    logic          l_gnt;
    logic          l_rvalid;
    logic [31:0]   l_rdata;
    logic          l_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    imem_access_arbiter #(
        .DEPTH(DEPTH), .AW(AW), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .l_err(l_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h0062E233 : 32'h1000_0000 + 32'(i);
    endfunction

    // Instruction memory array the arbiter drives; preload happens while preload=1.
    logic [31:0] mem [DEPTH];
    logic        preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic        rst;
        logic        f_req;
        logic [31:0] f_addr;
        logic        l_req;
        logic        l_we;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic        l_lock;
    } stim_t;

    typedef struct {
        stim_t       in;
        logic        f_gnt;
        logic        l_gnt;
        logic        mem_en;
        logic        f_rvalid;
        logic [31:0] f_rdata;
        logic        f_err;
        logic        l_rvalid;
        logic [31:0] l_rdata;
        logic        l_err;
    } vec_t;

    int assert_count = 0;
    int fail_count   = 0;
    int cycle        = 0;

    // Reference model state: memory contents and the response owed next cycle.
    logic [31:0] ref_mem [DEPTH];
    int          m_starve;
    int          p_owner;
    bit          p_err;
    logic [31:0] p_data;
    int          n_owner;
    bit          n_err;
    logic [31:0] n_data;
    bit          n_fg;
    bit          n_we;
    int          n_word;
    logic [31:0] n_wdata;

    function automatic stim_t mk(input logic r, input logic fq, input logic [31:0] fa,
                                 input logic lq, input logic lw, input logic [31:0] la,
                                 input logic [31:0] ld, input logic lk);
        stim_t s;
        s.rst = r; s.f_req = fq; s.f_addr = fa; s.l_req = lq;
        s.l_we = lw; s.l_addr = la; s.l_wdata = ld; s.l_lock = lk;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic fg, input logic lg,
                                 input logic en, input logic frv, input logic [31:0] frd,
                                 input logic fer, input logic lrv, input logic [31:0] lrd,
                                 input logic ler);
        vec_t v;
        v.in = s; v.f_gnt = fg; v.l_gnt = lg; v.mem_en = en;
        v.f_rvalid = frv; v.f_rdata = frd; v.f_err = fer;
        v.l_rvalid = lrv; v.l_rdata = lrd; v.l_err = ler;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        int          r;
        logic [31:0] w;
        r = $urandom_range(0, 19);
        w = 32'($urandom_range(0, 15));
        if (r == 0) return (w << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return 32'(DEPTH * 4) + (w << 2);
        if (r == 2) return $urandom;
        return w << 2;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
                     name, cycle, actual, expected);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        rst = s.rst; f_req = s.f_req; f_addr = s.f_addr; l_req = s.l_req;
        l_we = s.l_we; l_addr = s.l_addr; l_wdata = s.l_wdata; l_lock = s.l_lock;
        #1;
    endtask

    // Predict this cycle's grant from the arbitration rules and compare the
    // combinational outputs plus the response owed from the previous grant.
    task automatic checkModel();
        bit          fg;
        bit          lg;
        bit          flt;
        logic [31:0] a;
        fg = 1'b0;
        lg = 1'b0;
        if (rst) begin
            if (l_lock) lg = l_req;
            else if (m_starve == STARVE_LIMIT && f_req) fg = 1'b1;
            else if (l_req) lg = 1'b1;
            else fg = f_req;
        end
        a   = lg ? l_addr : f_addr;
        flt = (a % 4 != 0) || ((a / 4) >= 32'(DEPTH));
        checkOutput("f_gnt", 32'(f_gnt), 32'(fg));
        checkOutput("l_gnt", 32'(l_gnt), 32'(lg));
        checkOutput("mem_en", 32'(mem_en), 32'((fg || lg) && !flt));
        checkOutput("mem_we", 32'(mem_we), 32'(lg && l_we && !flt));
        if ((fg || lg) && !flt) checkOutput("mem_addr", 32'(mem_addr), a / 4);
        if (lg && l_we && !flt) checkOutput("mem_wdata", mem_wdata, l_wdata);
        checkOutput("f_rvalid", 32'(f_rvalid), 32'(p_owner == 1));
        checkOutput("f_rdata", f_rdata, (p_owner == 1) ? p_data : 32'h0);
        checkOutput("f_err", 32'(f_err), 32'(p_owner == 1 && p_err));
        checkOutput("l_rvalid", 32'(l_rvalid), 32'(p_owner == 2));
        checkOutput("l_rdata", l_rdata, (p_owner == 2) ? p_data : 32'h0);
        checkOutput("l_err", 32'(l_err), 32'(p_owner == 2 && p_err));
        n_fg    = fg;
        n_owner = lg ? 2 : (fg ? 1 : 0);
        n_err   = (fg || lg) && flt;
        n_we    = lg && l_we && !flt;
        n_word  = flt ? 0 : int'(a / 4);
        n_wdata = l_wdata;
        n_data  = ((fg || lg) && !flt && !(lg && l_we)) ? ref_mem[n_word] : 32'h0;
    endtask

    task automatic advance(input bit drop_rst);
        if (drop_rst) rst = 1'b0;
        @(posedge clk);
        cycle++;
        if (!rst) begin
            m_starve = 0; p_owner = 0; p_err = 1'b0; p_data = 32'h0;
        end else begin
            if (n_we) ref_mem[n_word] = n_wdata;
            p_owner = n_owner; p_err = n_err; p_data = n_data;
            if (l_lock || !f_req || n_fg) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
        end
    endtask

    vec_t  vecs [12];
    stim_t s;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        m_starve = 0; p_owner = 0; p_err = 1'b0; p_data = 32'h0;

        vecs[0]  = mkv(mk(0, 0, 32'h0,  0, 0, 32'h0,    32'h0,        0), 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0);
        vecs[1]  = mkv(mk(0, 1, 32'h0,  0, 0, 32'h0,    32'h0,        0), 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0);
        vecs[2]  = mkv(mk(1, 1, 32'h0,  0, 0, 32'h0,    32'h0,        0), 1, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0);
        vecs[3]  = mkv(mk(1, 1, 32'h4,  0, 0, 32'h0,    32'h0,        0), 1, 0, 1, 1, 32'h0062E233, 0, 0, 32'h0,        0);
        vecs[4]  = mkv(mk(1, 1, 32'h8,  0, 0, 32'h0,    32'h0,        0), 1, 0, 1, 1, 32'h10000001, 0, 0, 32'h0,        0);
        vecs[5]  = mkv(mk(1, 0, 32'h0,  1, 1, 32'h10,   32'hDEADBEEF, 0), 0, 1, 1, 1, 32'h10000002, 0, 0, 32'h0,        0);
        vecs[6]  = mkv(mk(1, 1, 32'h10, 0, 0, 32'h0,    32'h0,        0), 1, 0, 1, 0, 32'h0,        0, 1, 32'h0,        0);
        vecs[7]  = mkv(mk(1, 0, 32'h0,  0, 0, 32'h0,    32'h0,        0), 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0);
        vecs[8]  = mkv(mk(1, 1, 32'h6,  0, 0, 32'h0,    32'h0,        0), 1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0);
        vecs[9]  = mkv(mk(1, 0, 32'h0,  1, 1, 32'h1000, 32'hBADBAD00, 0), 0, 1, 0, 1, 32'h0,        1, 0, 32'h0,        0);
        vecs[10] = mkv(mk(1, 0, 32'h0,  1, 0, 32'h0,    32'h0,        0), 0, 1, 1, 0, 32'h0,        0, 1, 32'h0,        1);
        vecs[11] = mkv(mk(1, 0, 32'h0,  0, 0, 32'h0,    32'h0,        0), 0, 0, 0, 0, 32'h0,        0, 1, 32'h0062E233, 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
            advance(0);
        end
        preload = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].in);
            checkModel();
            checkOutput("vec_f_gnt", 32'(f_gnt), 32'(vecs[i].f_gnt));
            checkOutput("vec_l_gnt", 32'(l_gnt), 32'(vecs[i].l_gnt));
            checkOutput("vec_mem_en", 32'(mem_en), 32'(vecs[i].mem_en));
            checkOutput("vec_f_rvalid", 32'(f_rvalid), 32'(vecs[i].f_rvalid));
            checkOutput("vec_f_rdata", f_rdata, vecs[i].f_rdata);
            checkOutput("vec_f_err", 32'(f_err), 32'(vecs[i].f_err));
            checkOutput("vec_l_rvalid", 32'(l_rvalid), 32'(vecs[i].l_rvalid));
            checkOutput("vec_l_rdata", l_rdata, vecs[i].l_rdata);
            checkOutput("vec_l_err", 32'(l_err), 32'(vecs[i].l_err));
            advance(0);
        end

        $display("[TB] reset in the middle of a fetch");
        applyStimulus(mk(1, 1, 32'hC, 0, 0, 32'h0, 32'h0, 0));
        checkModel();
        checkOutput("rst_mid_f_gnt", 32'(f_gnt), 32'd1);
        advance(1);
        applyStimulus(mk(1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0));
        checkModel();
        checkOutput("rst_dropped_f_rvalid", 32'(f_rvalid), 32'd0);
        checkOutput("rst_dropped_f_rdata", f_rdata, 32'h0);
        checkOutput("rst_after_f_gnt", 32'(f_gnt), 32'd1);
        advance(0);
        applyStimulus(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
        checkModel();
        checkOutput("rst_after_f_rdata", f_rdata, 32'h0062E233);
        advance(0);

        $display("[TB] starvation and loader lock");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(mk(1, 1, 32'h20, 1, 0, 32'h24, 32'h0, 0));
            checkModel();
            checkOutput("starve_f_gnt", 32'(f_gnt), 32'(i % 5 == 4));
            checkOutput("starve_l_gnt", 32'(l_gnt), 32'(i % 5 != 4));
            advance(0);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(mk(1, 1, 32'h20, 1, 0, 32'h24, 32'h0, 1));
            checkModel();
            checkOutput("lock_f_gnt", 32'(f_gnt), 32'd0);
            checkOutput("lock_l_gnt", 32'(l_gnt), 32'd1);
            advance(0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mk(1, 1, 32'h20, 1, 0, 32'h24, 32'h0, 0));
            checkModel();
            checkOutput("unlock_f_gnt", 32'(f_gnt), 32'(i == 4));
            advance(0);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            s.rst     = ($urandom_range(0, 63) != 0);
            s.f_req   = ($urandom_range(0, 3) != 0);
            s.f_addr  = rand_addr();
            s.l_req   = 1'($urandom_range(0, 1));
            s.l_we    = 1'($urandom_range(0, 1));
            s.l_addr  = rand_addr();
            s.l_wdata = $urandom;
            s.l_lock  = ($urandom_range(0, 7) == 0);
            applyStimulus(s);
            checkModel();
            advance(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Shares one single-port, synchronous-read instruction memory between two requesters:
  - the core fetch unit (read-only);
  - the program loader/debug port (read and write).
- Issues at most one memory access per cycle; read data returns one cycle later, routed to the requester that issued the access.
- Sits between the fetch stage / loader and the instruction memory array, replacing direct fetch-to-memory wiring.

Parameters:
DEPTH, 1024, instruction memory depth in 32-bit words
AW, 10, memory word-address width (clog2(DEPTH))
STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win one slot (1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low
f_req  input  1  fetch read request
f_addr  input  32  fetch byte address
f_gnt  output  1  fetch request accepted this cycle (combinational)
f_rvalid  output  1  fetch response valid (registered)
f_rdata  output  32  fetch read data
f_err  output  1  fetch response is a fault (qualified by f_rvalid)
l_req  input  1  loader request
l_we  input  1  loader write (1) / read (0)
l_addr  input  32  loader byte address
l_wdata  input  32  loader write data
l_lock  input  1  loader-only mode: fetch never granted
l_gnt  output  1  loader request accepted this cycle (combinational)
l_rvalid  output  1  loader response valid (reads and writes)
l_rdata  output  32  loader read data (0 for writes)
l_err  output  1  loader response is a fault
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  AW  memory word address (byte address [AW+1:2])
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid one cycle after mem_en

Behaviour:
- Reset (rst=0 at a clock edge):
  - f_rvalid, l_rvalid, f_err and l_err are 0.
  - f_rdata and l_rdata are 0.
  - Starvation counter and response-owner register are cleared.
  - A response pending at reset is dropped: no rvalid follows reset.
  - Grants and mem_en are 0 while rst=0.
- Arbitration (combinational, per cycle; at most one grant):
  - l_lock=1: only the loader can be granted; the starvation counter holds at 0.
  - Otherwise, if starve_cnt==STARVE_LIMIT and f_req=1, fetch is granted.
  - Otherwise the loader has priority over fetch.
  - A granted request is consumed that cycle; requesters present new addresses the next cycle.
- Address check on the granted request:
  - Fault if addr[1:0]!=0 or addr[31:2]>=DEPTH.
  - A faulting request is still granted but does not drive the memory: mem_en=0 and mem_we=0.
  - Its response arrives next cycle with err=1 and rdata=0.
  - A faulting loader write does not modify memory.
- Memory drive for a granted, non-faulting request: mem_en=1; mem_we=l_we for the loader, 0 for fetch; mem_addr=addr[AW+1:2]; mem_wdata=l_wdata.
- Response (1-cycle latency): the owner and type of cycle N's grant are registered.
  - In cycle N+1 exactly one of f_rvalid/l_rvalid is 1.
  - rdata=mem_rdata for reads, 0 for writes.
  - Fully pipelined: back-to-back grants give back-to-back responses, and ownership may alternate every cycle.
- Starvation counter (0..STARVE_LIMIT):
  - Increments when f_req=1, f_gnt=0 and l_lock=0.
  - Clears on f_gnt=1 or f_req=0.
  - Saturates at STARVE_LIMIT.
- Hazard: a loader write in cycle N followed by a read of the same address in cycle N+1 returns the new data; no bypass is needed.
- Idle cycle (no grant): mem_en=0, and both rvalids are 0 the following cycle.

Test Plan:
- Fetch only: f_req=1 with f_addr=0x0, 0x4, 0x8 on consecutive cycles, memory preloaded with 0x0062E233 at word 0 -> f_gnt=1 every cycle; f_rvalid=1 from cycle 2 onward; f_rdata=0x0062E233 first; mem_we=0 throughout.
- Loader write then fetch read: write 0xDEADBEEF to 0x10, then fetch 0x10 the next cycle -> l_rvalid with l_rdata=0; next cycle f_rdata=0xDEADBEEF.
- Starvation: l_req held high, f_req held high, STARVE_LIMIT=4 -> loader granted 4 cycles, fetch granted on the 5th, then the loader resumes; with l_lock=1 fetch is never granted over 20 cycles.
- Faults: fetch 0x6, and loader write to 0x1000 with DEPTH=1024 -> mem_en=0 for both; responses have err=1 and rdata=0; a later read of word 0 is unchanged.
- Reset mid-operation: fetch granted in cycle N, rst=0 at edge N+1 -> f_rvalid=0, f_rdata=0, starve_cnt=0; after rst=1 the first grant behaves normally.
